mux_display_scan_drv: RTL and testbench
=======================================

Name: mux_display_scan_drv

Overview:
- Parametrised successor to the fixed four-digit segment driver.
- Time-multiplexes N_DIGITS common-drain 8-segment digits from one clock using clock-enable prescaling; no derived clocks.
- Adds per-digit hex decode or raw-segment mode, leading-zero blanking, PWM brightness, anti-ghosting dead time, and tear-free double-buffered loads applied at frame boundaries.
- Sits between data sources (LFSR, counters, CPU port) and the board's digit drains and segment lines.

Parameters:
N_DIGITS, 4, number of digits scanned; must be >= 1
SCAN_DIV, 65536, clocks per digit slot; must be > DEAD_CYCLES
DEAD_CYCLES, 16, clocks at the start of each slot with all drains inactive
PWM_BITS, 4, width of the brightness control and the PWM counter
DRAIN_ACT_LOW, 1, 1 = drain outputs active-low
SEG_ACT_LOW, 0, 1 = segment outputs active-low

Ports:
i_CLK  in  1  system clock; all logic on posedge
i_RST_N  in  1  reset; asynchronous, active-low
i_Data  in  8*N_DIGITS  byte k drives digit k; hex mode uses bits [3:0] of byte k
i_Dp  in  N_DIGITS  decimal point per digit
i_Raw_Mode  in  1  0 = hex decode, 1 = byte is the raw segment pattern
i_Lz_Blank  in  1  enable leading-zero blanking (hex mode only)
i_Data_DV  in  1  one-clock strobe; captures i_Data, i_Dp, i_Raw_Mode, i_Lz_Blank into the pending buffer
i_Brightness  in  PWM_BITS  on-duty numerator; 0 = dark
o_Drains  out  N_DIGITS  digit select, polarity per DRAIN_ACT_LOW
o_Segs  out  8  segments: bit0..6 = a..g, bit7 = dp; polarity per SEG_ACT_LOW
o_Frame  out  1  one-clock pulse when pending data becomes active

Behaviour:
- Reset (async assert):
  - slot_cnt, digit index, and pwm_cnt = 0.
  - Active buffer = all zero, hex mode, no blanking, dp off. Pending-valid = 0.
  - o_Drains = all inactive. o_Segs = all off at the configured polarity. o_Frame = 0.
  - Outputs take these values immediately, without waiting for a clock edge.
  - Release is used as-is; the synchroniser lives upstream.
- Counters:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps. On wrap the digit index advances 0,1,...,N_DIGITS-1 and then returns to 0.
  - pwm_cnt is a free-running PWM_BITS counter, incremented every clock, unaffected by slot boundaries.
- Frame boundary:
  - Defined as the clock where slot_cnt == SCAN_DIV-1 and digit == N_DIGITS-1.
  - On that clock, if pending-valid is set: active <= pending, pending-valid cleared, o_Frame = 1 on the next clock.
  - If pending-valid is not set, o_Frame stays 0.
- Load handshake:
  - i_Data_DV writes the pending buffer and sets pending-valid.
  - A repeat DV before the boundary overwrites pending (last write wins).
  - DV on the boundary clock: the transfer uses the old pending contents; the new capture stays pending with pending-valid = 1 and is applied at the next boundary.
- Segment pattern for the current digit k, from the active buffer:
  - Raw mode: pattern = byte k, with bit7 ORed with dp[k].
  - Hex mode: 0..F -> 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71; bit7 = dp[k]; data bits [7:4] ignored.
  - Lz blank (hex mode only): digit k is blanked when nibbles k..N_DIGITS-1 are all zero and k != 0. A blanked digit shows only dp[k]. Digit 0 is never blanked.
- Drive:
  - Drain k is active iff slot_cnt >= DEAD_CYCLES AND pwm_cnt < i_Brightness.
  - Maximum brightness gives (2^PWM_BITS-1)/2^PWM_BITS duty.
  - Segments are driven throughout the slot, including the dead time.
  - i_Brightness is used live and is not buffered.
- Latency: o_Drains and o_Segs are registered, one clock after the counter state that produces them.
- At most one drain is active in any cycle.

Test Plan:
- Common parameters for all scenarios: N_DIGITS=4, SCAN_DIV=32, DEAD_CYCLES=4, PWM_BITS=2, DRAIN_ACT_LOW=1, SEG_ACT_LOW=0.
1. Reset, then brightness 3, no load -> every digit shows segs 0x3F; for each slot of 32 clocks, drains are 4'b1111 for the first 4 clocks, then the selected drain bit is low 3 of every 4 clocks; order is digit 0,1,2,3.
2. DV with i_Data=32'h0F0A0301, i_Dp=4'b0010, hex mode at clock 10 -> no change until the frame boundary (clock 127); o_Frame pulses once; next frame shows digits 0..3 = 0x06, 0xCF, 0x77, 0x71.
3. Lz blank on, data 32'h00000005 -> digits 3..1 segs 0x00, digit 0 segs 0x6D; data 32'h00000000 -> digit 0 0x3F, others 0x00; data 32'h00050000 -> digit 3 0x00, digits 2..0 = 0x6D, 0x3F, 0x3F.
4. Brightness 0 -> drains stay 4'b1111 throughout; brightness 2 -> active exactly when pwm_cnt is 0 or 1 after dead time.
5. Tearing: DV with A at clock 20, B at clock 60 -> only B appears after the boundary, with a single o_Frame pulse; DV with C on the boundary clock -> C applies at the following boundary with a second o_Frame pulse.
6. Async reset asserted mid-slot on digit 2 -> o_Drains=4'b1111 and o_Segs=0 immediately; after release, scanning restarts at digit 0 showing 0x3F.

Source files
------------

// File: rtl/mux_display_scan_drv.sv
// Purpose: time-multiplexed N-digit 8-segment scan driver with hex/raw decode, LZ blanking, PWM, dead time.
// Latency: o_Drains/o_Segs registered one clock after the counter state producing them; o_Frame one clock after boundary.
// Backpressure: none; i_Data_DV always accepted into pending buffer (last write wins), applied at frame boundary.
module mux_display_scan_drv #(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV      = 65536,
    parameter int DEAD_CYCLES   = 16,
    parameter int PWM_BITS      = 4,
    parameter int DRAIN_ACT_LOW = 1,
    parameter int SEG_ACT_LOW   = 0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic [8*N_DIGITS-1:0] i_Data,
    input  logic [N_DIGITS-1:0]   i_Dp,
    input  logic                  i_Raw_Mode,
    input  logic                  i_Lz_Blank,
    input  logic                  i_Data_DV,
    input  logic [PWM_BITS-1:0]   i_Brightness,
    output logic [N_DIGITS-1:0]   o_Drains,
    output logic [7:0]            o_Segs,
    output logic                  o_Frame
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [SW-1:0]       SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]       DEAD_END  = SW'(DEAD_CYCLES);
    localparam logic [DW-1:0]       DIG_LAST  = DW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DRAIN_OFF = (DRAIN_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]          SEG_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [8*N_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                  pend_raw_q, pend_raw_d, act_raw_q, act_raw_d;
    logic                  pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [N_DIGITS-1:0]   drains_q, drains_d;
    logic [7:0]            segs_q, segs_d;
    logic                  frame_q, frame_d;

    logic                  boundary;
    logic [7:0]            cur_byte;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  upper_zero;
    logic                  drain_on;
    logic [N_DIGITS-1:0]   drn_sel;
    logic [7:0]            pat;

    // Select the current digit's byte/dp and decide leading-zero blanking from the active buffer.
    always_comb begin
        cur_byte   = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (act_data_q[8*k +: 4] == 4'h0);
            if (DW'(k) == digit_q) begin
                cur_byte  = act_data_q[8*k +: 8];
                cur_dp    = act_dp_q[k];
                cur_blank = upper_zero && (k != 0);
            end
        end
    end

    // Next-state for counters, buffers and the registered drain/segment/frame outputs.
    always_comb begin
        boundary    = (slot_cnt_q == SLOT_LAST) && (digit_q == DIG_LAST);
        slot_cnt_d  = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SW'(1);
        digit_d     = digit_q;
        if (slot_cnt_q == SLOT_LAST) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
        end
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);

        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_raw_d   = act_raw_q;
        act_lz_d    = act_lz_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_raw_d  = pend_raw_q;
        pend_lz_d   = pend_lz_q;
        pend_vld_d  = pend_vld_q;
        frame_d     = boundary && pend_vld_q;

        // Transfer uses the old pending contents; a same-clock capture stays pending.
        if (boundary && pend_vld_q) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            act_raw_d  = pend_raw_q;
            act_lz_d   = pend_lz_q;
            pend_vld_d = 1'b0;
        end
        if (i_Data_DV) begin
            pend_data_d = i_Data;
            pend_dp_d   = i_Dp;
            pend_raw_d  = i_Raw_Mode;
            pend_lz_d   = i_Lz_Blank;
            pend_vld_d  = 1'b1;
        end

        if (act_raw_q) begin
            pat = {cur_byte[7] | cur_dp, cur_byte[6:0]};
        end else if (act_lz_q && cur_blank) begin
            pat = {cur_dp, 7'h00};
        end else begin
            pat = {cur_dp, hex7(cur_byte[3:0])};
        end
        segs_d = (SEG_ACT_LOW != 0) ? ~pat : pat;

        drain_on = (slot_cnt_q >= DEAD_END) && (pwm_cnt_q < i_Brightness);
        drn_sel  = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            drn_sel[k] = drain_on && (DW'(k) == digit_q);
        end
        drains_d = (DRAIN_ACT_LOW != 0) ? ~drn_sel : drn_sel;
    end

    // State register; reset forces outputs inactive immediately.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            slot_cnt_q  <= '0;
            digit_q     <= '0;
            pwm_cnt_q   <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_raw_q  <= 1'b0;
            pend_lz_q   <= 1'b0;
            pend_vld_q  <= 1'b0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_raw_q   <= 1'b0;
            act_lz_q    <= 1'b0;
            drains_q    <= DRAIN_OFF;
            segs_q      <= SEG_OFF;
            frame_q     <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_q     <= digit_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_raw_q  <= pend_raw_d;
            pend_lz_q   <= pend_lz_d;
            pend_vld_q  <= pend_vld_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_raw_q   <= act_raw_d;
            act_lz_q    <= act_lz_d;
            drains_q    <= drains_d;
            segs_q      <= segs_d;
            frame_q     <= frame_d;
        end
    end

    assign o_Drains = drains_q;
    assign o_Segs   = segs_q;
    assign o_Frame  = frame_q;

endmodule

// File: tb/tb_mux_display_scan_drv.sv
// Bench for mux_display_scan_drv: N=4, SCAN_DIV=32, DEAD=4, PWM_BITS=2, drains active-low, segs active-high.
// A frame is 128 clocks; a cycle-count reference model predicts every output each clock.
// Inputs change on negedge, outputs sampled on negedge.
module tb_mux_display_scan_drv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data = '0;
    logic [3:0]  dp = '0;
    logic        raw = 1'b0, lz = 1'b0, dv = 1'b0;
    logic [1:0]  bright = 2'd0;
    logic [3:0]  o_Drains;
    logic [7:0]  o_Segs;
    logic        o_Frame;

    int n_chk = 0;
    int n_fail = 0;

    mux_display_scan_drv #(
        .N_DIGITS(4), .SCAN_DIV(32), .DEAD_CYCLES(4), .PWM_BITS(2),
        .DRAIN_ACT_LOW(1), .SEG_ACT_LOW(0)
    ) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_Data(data), .i_Dp(dp),
        .i_Raw_Mode(raw), .i_Lz_Blank(lz), .i_Data_DV(dv), .i_Brightness(bright),
        .o_Drains(o_Drains), .o_Segs(o_Segs), .o_Frame(o_Frame)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_cyc;
    logic [31:0] m_act_data, m_pend_data;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_act_raw, m_act_lz, m_pend_raw, m_pend_lz, m_pend_vld;
    logic [3:0]  exp_drains;
    logic [7:0]  exp_segs;
    logic        exp_frame;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [3:0] model_drains(input int t, input logic [1:0] b);
        int slot, dig, pwm;
        slot = t % 32;
        dig  = (t / 32) % 4;
        pwm  = t % 4;
        if (slot >= 4 && pwm < int'(b)) return ~(4'b0001 << dig);
        return 4'hF;
    endfunction

    function automatic logic [7:0] model_segs(input logic [31:0] d, input logic [3:0] p,
                                              input logic r, input logic l, input int k);
        logic [7:0] b;
        logic       blank;
        b = d[8*k +: 8];
        if (r) return b | {p[k], 7'h00};
        blank = l && (k != 0);
        for (int j = k; j < 4; j++) if (d[8*j +: 4] != 4'h0) blank = 1'b0;
        if (blank) return {p[k], 7'h00};
        return {p[k], hex_seg(b[3:0])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0; m_act_data <= '0; m_act_dp <= '0; m_act_raw <= 1'b0; m_act_lz <= 1'b0;
            m_pend_data <= '0; m_pend_dp <= '0; m_pend_raw <= 1'b0; m_pend_lz <= 1'b0; m_pend_vld <= 1'b0;
            exp_drains <= 4'hF; exp_segs <= 8'h00; exp_frame <= 1'b0;
        end else begin
            exp_drains <= model_drains(m_cyc, bright);
            exp_segs   <= model_segs(m_act_data, m_act_dp, m_act_raw, m_act_lz, (m_cyc / 32) % 4);
            exp_frame  <= (m_cyc % 128 == 127) && m_pend_vld;
            if (m_cyc % 128 == 127 && m_pend_vld) begin
                m_act_data <= m_pend_data; m_act_dp <= m_pend_dp;
                m_act_raw <= m_pend_raw; m_act_lz <= m_pend_lz; m_pend_vld <= 1'b0;
            end
            if (dv) begin
                m_pend_data <= data; m_pend_dp <= dp; m_pend_raw <= raw; m_pend_lz <= lz; m_pend_vld <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    // ---------------- non-checking helpers ----------------
    function automatic int act_digit(input logic [3:0] dr);
        for (int k = 0; k < 4; k++) if (dr[k] == 1'b0) return k;
        return -1;
    endfunction

    task automatic sync_to(input int x);
        int n = 0;
        while ((m_cyc % 128) != x && n < 300) begin @(negedge clk); n++; end
        if ((m_cyc % 128) != x) begin
            n_chk++; n_fail++;
            $display("FAIL sync_to timeout: position %0d, required %0d", m_cyc % 128, x);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; bright = 2'd3;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (o_Drains !== 4'hF) begin n_fail++; $display("FAIL reset_drains got %b need 1111", o_Drains); end
        n_chk++; if (o_Segs !== 8'h00) begin n_fail++; $display("FAIL reset_segs got %h need 00", o_Segs); end
        n_chk++; if (o_Frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b need 0", o_Frame); end
        repeat (2) @(negedge clk);
        n_chk++; if (o_Drains !== 4'hF || o_Segs !== 8'h00) begin
            n_fail++; $display("FAIL reset_held drains %b segs %h need 1111/00", o_Drains, o_Segs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int active = 0;
        bright = 2'd3;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_Drains !== exp_drains || o_Segs !== exp_segs || o_Frame !== exp_frame || !$onehot0(~o_Drains)) begin
                n_fail++; $display("FAIL scan t=%0d drains %b/%b segs %h/%h frame %b/%b", m_cyc, o_Drains, exp_drains, o_Segs, exp_segs, o_Frame, exp_frame);
            end
            if (o_Drains != 4'hF) active++;
        end
        n_chk++; if (active != 168) begin n_fail++; $display("FAIL scan_duty active %0d need 168", active); end
    endtask

    task automatic test_load();
        int frames = 0;
        logic post = 1'b0;
        logic [31:0] seen = 32'hEEEEEEEE;
        sync_to(10);
        data = 32'h0F0A0301; dp = 4'b0010; raw = 1'b0; lz = 1'b0; dv = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dv = 1'b0;
            n_chk++;
            if (o_Drains !== exp_drains || o_Segs !== exp_segs || o_Frame !== exp_frame || !$onehot0(~o_Drains)) begin
                n_fail++; $display("FAIL load t=%0d drains %b/%b segs %h/%h frame %b/%b", m_cyc, o_Drains, exp_drains, o_Segs, exp_segs, o_Frame, exp_frame);
            end
            if (o_Frame) begin frames++; post = 1'b1; end
            else if (post && act_digit(o_Drains) >= 0) seen[8*act_digit(o_Drains) +: 8] = o_Segs;
        end
        n_chk++; if (frames != 1) begin n_fail++; $display("FAIL load_frames got %0d need 1", frames); end
        n_chk++; if (seen !== 32'h7177CF06) begin n_fail++; $display("FAIL load_segs got %h need 7177CF06", seen); end
    endtask

    task automatic test_lz();
        logic [31:0] v, e, seen;
        int frames;
        logic post;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin v = 32'h00000005; e = 32'h0000006D; end
                1: begin v = 32'h00000000; e = 32'h0000003F; end
                default: begin v = 32'h00050000; e = 32'h006D3F3F; end
            endcase
            data = v; dp = 4'b0000; raw = 1'b0; lz = 1'b1; dv = 1'b1;
            frames = 0; post = 1'b0; seen = 32'hEEEEEEEE;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                dv = 1'b0;
                n_chk++;
                if (o_Drains !== exp_drains || o_Segs !== exp_segs || o_Frame !== exp_frame) begin
                    n_fail++; $display("FAIL lz%0d t=%0d drains %b/%b segs %h/%h frame %b/%b", c, m_cyc, o_Drains, exp_drains, o_Segs, exp_segs, o_Frame, exp_frame);
                end
                if (o_Frame) begin frames++; post = 1'b1; end
                else if (post && act_digit(o_Drains) >= 0) seen[8*act_digit(o_Drains) +: 8] = o_Segs;
            end
            n_chk++; if (frames != 1) begin n_fail++; $display("FAIL lz%0d_frames got %0d need 1", c, frames); end
            n_chk++; if (seen !== e) begin n_fail++; $display("FAIL lz%0d_segs got %h need %h", c, seen, e); end
        end
    endtask

    task automatic test_brightness();
        int active;
        for (int c = 0; c < 2; c++) begin
            bright = (c == 0) ? 2'd0 : 2'd2;
            active = 0;
            for (int i = 0; i < 128; i++) begin
                @(negedge clk);
                n_chk++;
                if (o_Drains !== exp_drains || o_Segs !== exp_segs) begin
                    n_fail++; $display("FAIL bright%0d t=%0d drains %b/%b segs %h/%h", bright, m_cyc, o_Drains, exp_drains, o_Segs, exp_segs);
                end
                if (o_Drains != 4'hF) active++;
            end
            n_chk++;
            if (active != ((c == 0) ? 0 : 56)) begin
                n_fail++; $display("FAIL bright%0d_duty active %0d need %0d", bright, active, (c == 0) ? 0 : 56);
            end
        end
        bright = 2'd3;
    endtask

    task automatic test_tearing();
        int frames = 0;
        logic post = 1'b0;
        logic [31:0] seen = 32'hEEEEEEEE, seen_b = 32'hEEEEEEEE;
        raw = 1'b1; lz = 1'b0; dp = 4'b0000;
        sync_to(20);  data = 32'hFFFFFFFF; dv = 1'b1; @(negedge clk); dv = 1'b0;
        sync_to(60);  data = 32'h12345678; dv = 1'b1; @(negedge clk); dv = 1'b0;
        sync_to(127); data = 32'h11223344; dp = 4'b0101; dv = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dv = 1'b0;
            n_chk++;
            if (o_Drains !== exp_drains || o_Segs !== exp_segs || o_Frame !== exp_frame) begin
                n_fail++; $display("FAIL tear t=%0d drains %b/%b segs %h/%h frame %b/%b", m_cyc, o_Drains, exp_drains, o_Segs, exp_segs, o_Frame, exp_frame);
            end
            if (o_Frame) begin
                if (frames == 1) seen_b = seen;
                frames++; post = 1'b1; seen = 32'hEEEEEEEE;
            end else if (post && act_digit(o_Drains) >= 0) seen[8*act_digit(o_Drains) +: 8] = o_Segs;
        end
        n_chk++; if (frames != 2) begin n_fail++; $display("FAIL tear_frames got %0d need 2", frames); end
        n_chk++; if (seen_b !== 32'h12345678) begin n_fail++; $display("FAIL tear_b got %h need 12345678", seen_b); end
        n_chk++; if (seen !== 32'h11A233C4) begin n_fail++; $display("FAIL tear_c got %h need 11A233C4", seen); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_Drains !== exp_drains || o_Segs !== exp_segs || o_Frame !== exp_frame || !$onehot0(~o_Drains)) begin
                n_fail++; $display("FAIL rand t=%0d drains %b/%b segs %h/%h frame %b/%b", m_cyc, o_Drains, exp_drains, o_Segs, exp_segs, o_Frame, exp_frame);
            end
            dv = ($urandom_range(0, 39) == 0);
            if (dv) begin
                data = $urandom; dp = 4'($urandom); raw = 1'($urandom); lz = 1'($urandom);
                if ($urandom_range(0, 2) == 0) data = data & 32'h000F0F0F;
            end
            if ($urandom_range(0, 99) == 0) bright = 2'($urandom);
        end
        dv = 1'b0; bright = 2'd3;
        repeat (300) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic got_first = 1'b0;
        sync_to(74);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (o_Drains !== 4'hF) begin n_fail++; $display("FAIL midrst_drains got %b need 1111", o_Drains); end
        n_chk++; if (o_Segs !== 8'h00) begin n_fail++; $display("FAIL midrst_segs got %h need 00", o_Segs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_Drains !== exp_drains || o_Segs !== exp_segs || o_Frame !== exp_frame) begin
                n_fail++; $display("FAIL midrst t=%0d drains %b/%b segs %h/%h frame %b/%b", m_cyc, o_Drains, exp_drains, o_Segs, exp_segs, o_Frame, exp_frame);
            end
            if (!got_first && o_Drains != 4'hF) begin
                got_first = 1'b1;
                n_chk++;
                if (o_Drains !== 4'b1110 || o_Segs !== 8'h3F) begin
                    n_fail++; $display("FAIL midrst_restart drains %b segs %h need 1110/3F", o_Drains, o_Segs);
                end
            end
        end
        n_chk++; if (!got_first) begin n_fail++; $display("FAIL midrst_no_drain got none need 1110"); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_lz();
        test_brightness();
        test_tearing();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
